// File: rtl/knn_pkg.sv
// Shared definitions for the KNN memory subsystem: default widths and the
// arbiter state encoding.
package knn_pkg;

  localparam int KNN_W      = 32;
  localparam int KNN_ADDR_W = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin winner selection: the search starts one past the previous
// winner and wraps, so the last winner has the lowest priority.
module rr_priority_pick #(
  parameter int R  = 2,
  parameter int IW = $clog2(R)
) (
  input  logic [R-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [R-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand;

  // Walk the R candidates in rotated order and take the first active one.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int i = 1; i <= R; i++) begin
      cand = (int'(last) + i) % R;
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/knn_mem_arbiter.sv
// Round-robin arbiter sharing the single KNN memory port between R
// requesters. One transaction is in flight at a time; read data is captured
// after a fixed memory latency and handed back to the requester that won.
module knn_mem_arbiter
  import knn_pkg::*;
#(
  parameter int W      = KNN_W,
  parameter int ADDR_W = KNN_ADDR_W,
  parameter int R      = 2,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [R-1:0]        req_read,
  input  logic [R-1:0]        req_write,
  input  logic [R*ADDR_W-1:0] req_addr,
  input  logic [R*W-1:0]      req_wdata,
  output logic [R-1:0]        gnt,
  output logic [R-1:0]        rvalid,
  output logic [W-1:0]        rdata,
  output logic                busy,
  output logic                read,
  output logic [ADDR_W-1:0]   readaddress,
  input  logic [W-1:0]        readdata,
  output logic                write,
  output logic [ADDR_W-1:0]   writeaddress,
  output logic [W-1:0]        writedata
);

  localparam int IW = $clog2(R);

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     last_q, last_d;
  logic [R-1:0]      win_q, win_d;
  logic              is_wr_q, is_wr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] readaddress_q, readaddress_d;
  logic [ADDR_W-1:0] writeaddress_q, writeaddress_d;
  logic [W-1:0]      writedata_q, writedata_d;
  logic [W-1:0]      rdata_q, rdata_d;

  logic [R-1:0]      pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;

  rr_priority_pick #(.R(R), .IW(IW)) u_pick (
    .req    (req_read | req_write),
    .last   (last_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Next-state logic: arbitrate in IDLE, pulse the strobe in ISSUE, then for
  // reads wait out the memory latency and present the captured data.
  // A requester raising both read and write gets its write serviced.
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    win_d          = win_q;
    is_wr_d        = is_wr_q;
    cnt_d          = cnt_q;
    readaddress_d  = readaddress_q;
    writeaddress_d = writeaddress_q;
    writedata_d    = writedata_q;
    rdata_d        = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          win_d   = pick_onehot;
          last_d  = pick_idx;
          is_wr_d = req_write[pick_idx];
          if (req_write[pick_idx]) begin
            writeaddress_d = req_addr[pick_idx*ADDR_W +: ADDR_W];
            writedata_d    = req_wdata[pick_idx*W +: W];
          end else begin
            readaddress_d  = req_addr[pick_idx*ADDR_W +: ADDR_W];
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = 3'd0;
        state_d = is_wr_q ? ST_IDLE : ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        if (cnt_q == 3'(RD_LAT - 1)) begin
          rdata_d = readdata;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register; reset leaves requester 0 first in line and drops any
  // read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      last_q         <= IW'(R - 1);
      win_q          <= '0;
      is_wr_q        <= 1'b0;
      cnt_q          <= 3'd0;
      readaddress_q  <= '0;
      writeaddress_q <= '0;
      writedata_q    <= '0;
      rdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      win_q          <= win_d;
      is_wr_q        <= is_wr_d;
      cnt_q          <= cnt_d;
      readaddress_q  <= readaddress_d;
      writeaddress_q <= writeaddress_d;
      writedata_q    <= writedata_d;
      rdata_q        <= rdata_d;
    end
  end

  assign gnt          = (state_q == ST_ISSUE) ? win_q : '0;
  assign rvalid       = (state_q == ST_RESP)  ? win_q : '0;
  assign read         = (state_q == ST_ISSUE) && !is_wr_q;
  assign write        = (state_q == ST_ISSUE) && is_wr_q;
  assign busy         = (state_q != ST_IDLE);
  assign readaddress  = readaddress_q;
  assign writeaddress = writeaddress_q;
  assign writedata    = writedata_q;
  assign rdata        = rdata_q;

endmodule

// File: tb/tb_knn_mem_arbiter.sv
// Directed bench for knn_mem_arbiter with R=2, RD_LAT=2: a cycle table for
// read, write and read+write collision, then hand sequences for reset during
// a read, round-robin fairness and request withdrawal.
module tb_knn_mem_arbiter;

  localparam int W      = 32;
  localparam int ADDR_W = 16;
  localparam int R      = 2;
  localparam int RD_LAT = 2;

  typedef struct {
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic        rd;
    logic        wr;
    logic        busy;
    logic [15:0] raddr;
    logic [15:0] waddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic [1:0]  rr;
    logic [1:0]  rw;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic [31:0] mem;
    exp_t        exp;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [R-1:0]      req_read;
  logic [R-1:0]      req_write;
  logic [R*ADDR_W-1:0] req_addr;
  logic [R*W-1:0]    req_wdata;
  logic [R-1:0]      gnt;
  logic [R-1:0]      rvalid;
  logic [W-1:0]      rdata;
  logic              busy;
  logic              read;
  logic [ADDR_W-1:0] readaddress;
  logic [W-1:0]      readdata;
  logic              write;
  logic [ADDR_W-1:0] writeaddress;
  logic [W-1:0]      writedata;

  int   check_count = 0;
  int   pass_count  = 0;
  logic overlap_seen = 1'b0;
  vec_t vecs[9];

  knn_mem_arbiter #(.W(W), .ADDR_W(ADDR_W), .R(R), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .busy         (busy),
    .read         (read),
    .readaddress  (readaddress),
    .readdata     (readdata),
    .write        (write),
    .writeaddress (writeaddress),
    .writedata    (writedata)
  );

  always #5 clk = ~clk;

  // Both strobes high together is never legal.
  always @(negedge clk) begin
    if (read && write) overlap_seen = 1'b1;
  end

  function automatic exp_t mkExp(logic [1:0] g, logic [1:0] rv, logic rd, logic wr,
                                 logic bz, logic [15:0] ra, logic [15:0] wa,
                                 logic [31:0] wd, logic [31:0] rdt);
    exp_t e;
    e.gnt = g; e.rvalid = rv; e.rd = rd; e.wr = wr; e.busy = bz;
    e.raddr = ra; e.waddr = wa; e.wdata = wd; e.rdata = rdt;
    return e;
  endfunction

  function automatic vec_t mkVec(logic [1:0] rr, logic [1:0] rw, logic [15:0] a0,
                                 logic [15:0] a1, logic [31:0] wd0, logic [31:0] wd1,
                                 logic [31:0] mem, exp_t e);
    vec_t v;
    v.rr = rr; v.rw = rw; v.a0 = a0; v.a1 = a1;
    v.wd0 = wd0; v.wd1 = wd1; v.mem = mem; v.exp = e;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(string name, logic [31:0] act, logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic checkOutput(string tag, exp_t e);
    checkField({tag, ".gnt"},          32'(gnt),          32'(e.gnt));
    checkField({tag, ".rvalid"},       32'(rvalid),       32'(e.rvalid));
    checkField({tag, ".read"},         32'(read),         32'(e.rd));
    checkField({tag, ".write"},        32'(write),        32'(e.wr));
    checkField({tag, ".busy"},         32'(busy),         32'(e.busy));
    checkField({tag, ".readaddress"},  32'(readaddress),  32'(e.raddr));
    checkField({tag, ".writeaddress"}, 32'(writeaddress), 32'(e.waddr));
    checkField({tag, ".writedata"},    writedata,         e.wdata);
    checkField({tag, ".rdata"},        rdata,             e.rdata);
  endtask

  task automatic applyStimulus(vec_t v);
    req_read  = v.rr;
    req_write = v.rw;
    req_addr  = {v.a1, v.a0};
    req_wdata = {v.wd1, v.wd0};
    readdata  = v.mem;
  endtask

  task automatic doReset();
    rst       = 1'b1;
    req_read  = '0;
    req_write = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int grants;
    int gnt1_seen;
    int rv0_seen;
    exp_t zero_exp;

    zero_exp  = mkExp(2'b00, 2'b00, 0, 0, 0, 16'h0, 16'h0, 32'h0, 32'h0);
    req_addr  = '0;
    req_wdata = '0;
    readdata  = '0;

    // Cycle table: expected outputs are those seen just after each edge.
    vecs[0] = mkVec(2'b01, 2'b00, 16'h0010, 16'h0000, 32'h0, 32'h0, 32'hDEADBEEF,
                    mkExp(2'b01, 2'b00, 1, 0, 1, 16'h0010, 16'h0000, 32'h0, 32'h0));
    vecs[1] = mkVec(2'b00, 2'b00, 16'h0010, 16'h0000, 32'h0, 32'h0, 32'hDEADBEEF,
                    mkExp(2'b00, 2'b00, 0, 0, 1, 16'h0010, 16'h0000, 32'h0, 32'h0));
    vecs[2] = mkVec(2'b00, 2'b00, 16'h0010, 16'h0000, 32'h0, 32'h0, 32'hDEADBEEF,
                    mkExp(2'b00, 2'b00, 0, 0, 1, 16'h0010, 16'h0000, 32'h0, 32'h0));
    vecs[3] = mkVec(2'b00, 2'b00, 16'h0010, 16'h0000, 32'h0, 32'h0, 32'hDEADBEEF,
                    mkExp(2'b00, 2'b01, 0, 0, 1, 16'h0010, 16'h0000, 32'h0, 32'hDEADBEEF));
    vecs[4] = mkVec(2'b00, 2'b10, 16'h0010, 16'h0200, 32'h0, 32'h5, 32'h0,
                    mkExp(2'b00, 2'b00, 0, 0, 0, 16'h0010, 16'h0000, 32'h0, 32'hDEADBEEF));
    vecs[5] = mkVec(2'b00, 2'b10, 16'h0010, 16'h0200, 32'h0, 32'h5, 32'h0,
                    mkExp(2'b10, 2'b00, 0, 1, 1, 16'h0010, 16'h0200, 32'h5, 32'hDEADBEEF));
    vecs[6] = mkVec(2'b00, 2'b00, 16'h0010, 16'h0200, 32'h0, 32'h5, 32'h0,
                    mkExp(2'b00, 2'b00, 0, 0, 0, 16'h0010, 16'h0200, 32'h5, 32'hDEADBEEF));
    vecs[7] = mkVec(2'b01, 2'b01, 16'h0300, 16'h0200, 32'hA5A5A5A5, 32'h5, 32'h0,
                    mkExp(2'b01, 2'b00, 0, 1, 1, 16'h0010, 16'h0300, 32'hA5A5A5A5, 32'hDEADBEEF));
    vecs[8] = mkVec(2'b00, 2'b00, 16'h0300, 16'h0200, 32'hA5A5A5A5, 32'h5, 32'h0,
                    mkExp(2'b00, 2'b00, 0, 0, 0, 16'h0010, 16'h0300, 32'hA5A5A5A5, 32'hDEADBEEF));

    doReset();
    step();
    checkOutput("reset", zero_exp);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Reset in the middle of a read: the read is dropped and requester 0
    // is first in line again afterwards.
    readdata  = 32'h12345678;
    req_addr  = {16'h0000, 16'h0040};
    req_read  = 2'b01;
    step();
    checkField("rstrd.gnt", 32'(gnt), 32'h1);
    checkField("rstrd.raddr", 32'(readaddress), 32'h0040);
    req_read = 2'b00;
    step();
    checkField("rstrd.wait_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rstrd.cleared", zero_exp);
    for (int i = 0; i < 4; i++) begin
      step();
      checkField($sformatf("rstrd.no_rvalid%0d", i), 32'(rvalid), 32'h0);
    end
    req_addr = {16'h0000, 16'h0044};
    req_read = 2'b01;
    step();
    checkField("rstrd.regnt", 32'(gnt), 32'h1);
    checkField("rstrd.reraddr", 32'(readaddress), 32'h0044);
    req_read = 2'b00;
    step();
    step();
    step();
    checkField("rstrd.rvalid", 32'(rvalid), 32'h1);
    checkField("rstrd.rdata", rdata, 32'h12345678);
    step();

    // Fairness: both requesters read continuously.
    doReset();
    req_addr = {16'h0101, 16'h0100};
    req_read = 2'b11;
    grants   = 0;
    for (int cyc = 0; cyc < 80 && grants < 6; cyc++) begin
      step();
      if (gnt != 2'b00) begin
        checkField($sformatf("fair.grant%0d", grants), 32'(gnt),
                   (grants % 2 == 0) ? 32'h1 : 32'h2);
        grants++;
      end
    end
    checkField("fair.grant_count", 32'(grants), 32'd6);
    req_read = 2'b00;
    for (int cyc = 0; cyc < 10 && busy; cyc++) step();
    checkField("fair.drained", 32'(busy), 32'h0);

    // Withdrawal: requester 1 gives up while requester 0 is being served.
    doReset();
    req_addr = {16'h0060, 16'h0050};
    req_read = 2'b11;
    step();
    checkField("wdraw.gnt0", 32'(gnt), 32'h1);
    req_read  = 2'b00;
    gnt1_seen = 0;
    rv0_seen  = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      step();
      if (gnt[1]) gnt1_seen++;
      if (rvalid[0]) rv0_seen++;
    end
    checkField("wdraw.no_gnt1", 32'(gnt1_seen), 32'd0);
    checkField("wdraw.rvalid0_once", 32'(rv0_seen), 32'd1);

    checkField("no_rd_wr_overlap", 32'(overlap_seen), 32'h0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
